// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronisers, clock glitch filter, framing, timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_byte #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 6000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       err_o,
    output logic       tmo_o
);
    import ps2_pkg::*;

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic          filt_prev_q;
    logic [FW-1:0] fcnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER - 1)) begin
                filt_q <= clk_sync_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    logic fall;
    logic dat;
    assign fall = filt_prev_q & ~filt_q;
    assign dat  = dat_sync_q[1];

    rx_state_e     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [TW-1:0] tcnt_q;
    logic          tmo_hit;
    logic          stop_ok;

    assign tmo_hit = (state_q != IDLE) && !fall
                   && (tcnt_q == TW'(TIMEOUT - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_ok_q;
    assign stop_ok = dat & par_ok_q;
`else
    assign stop_ok = dat;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tcnt_q     <= '0;
            byte_o     <= '0;
            byte_vld_o <= 1'b0;
            err_o      <= 1'b0;
            tmo_o      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            byte_vld_o <= 1'b0;
            err_o      <= 1'b0;
            tmo_o      <= 1'b0;
            if (state_q == IDLE || fall) begin
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            if (tmo_hit) begin
                state_q <= IDLE;
                err_o   <= 1'b1;
                tmo_o   <= 1'b1;
            end else if (fall) begin
                unique case (state_q)
                    IDLE: begin
                        bit_cnt_q <= '0;
                        if (!dat) state_q <= DATA;
                    end
                    DATA: begin
                        shift_q   <= {dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_ok_q <= ^{shift_q, dat};
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (stop_ok) begin
                            byte_o     <= shift_q;
                            byte_vld_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: E0/F0/E1 prefix sequencer and ps2_key register.
// Define PS2_PARITY_CHECK_EN to drop frames with bad parity.
module ps2_key_decoder #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 6000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        rx_err
);
    import ps2_pkg::*;

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        rx_tmo;
    logic [10:0] key_q;
    logic        ext_q;
    logic        brk_q;
    logic [2:0]  skip_q;

    ps2_rx_byte #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk_i      (clk_sys),
        .rst_ni     (RESET_N),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .err_o      (rx_err),
        .tmo_o      (rx_tmo)
    );

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else if (rx_tmo) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (rx_vld) begin
            priority case (1'b1)
                (skip_q != '0):         skip_q <= skip_q - 1'b1;
                (rx_byte == PS2_EXT):   ext_q  <= 1'b1;
                (rx_byte == PS2_BRK):   brk_q  <= 1'b1;
                (rx_byte == PS2_PAUSE): skip_q <= PAUSE_SKIP;
                default: begin
                    key_q[KEY_TOG]  <= ~key_q[KEY_TOG];
                    key_q[KEY_PRS]  <= ~brk_q;
                    key_q[KEY_EXT]  <= ext_q;
                    key_q[7:0]      <= rx_byte;
                    ext_q           <= 1'b0;
                    brk_q           <= 1'b0;
                end
            endcase
        end
    end

    assign ps2_key = key_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// byte streams checked against a behavioural model of the prefix rules.
module tb_ps2_key_decoder;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 6000;
    localparam int HALF    = 20;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        rx_err;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;

    logic [10:0] m_key;
    logic        m_ext;
    logic        m_brk;
    int          m_skip;
    int          m_err;

    ps2_key_decoder #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .RESET_N  (RESET_N),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .rx_err   (rx_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (rx_err === 1'b1) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    // Reference model: the prefix rules applied to one accepted byte.
    task automatic m_byte(input logic [7:0] b);
        if (m_skip != 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        RESET_N  = 1'b0;
        wait_cyc(4);
        m_key  = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
        RESET_N = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit flip,
                             input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit flip);
        send_bits(b, flip, 11);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
        if (PAR_EN && flip) m_err++;
        else m_byte(b);
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] b,
                             input bit flip);
        frame(b, flip);
        @(negedge clk_sys);
        chk({tag, "_key"}, 32'(ps2_key), 32'(m_key));
        chk({tag, "_err"}, 32'(err_seen), 32'(m_err));
    endtask

    initial begin
        logic [7:0] rb;
        bit         fl;
        int         r;
        m_err = 0;
        do_reset();
        @(negedge clk_sys);
        chk("reset_key", 32'(ps2_key), 32'h0);
        chk("reset_err", 32'(rx_err), 32'h0);

        frame(8'h1C, 1'b0);
        @(negedge clk_sys);
        chk("make_1c", 32'(ps2_key), 32'h61C);
        chk("make_1c_err", 32'(err_seen), 32'(0));

        frame(8'hF0, 1'b0);
        @(negedge clk_sys);
        chk("f0_no_event", 32'(ps2_key), 32'h61C);
        frame(8'h1C, 1'b0);
        @(negedge clk_sys);
        chk("break_1c", 32'(ps2_key), 32'h01C);

        frame(8'hE0, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h75, 1'b0);
        @(negedge clk_sys);
        chk("ext_break_75", 32'(ps2_key), 32'h575);
        frame(8'h75, 1'b0);
        @(negedge clk_sys);
        chk("make_75_noext", 32'(ps2_key), 32'h275);

        do_reset();
        frame(8'h1C, 1'b1);
        @(negedge clk_sys);
        chk("parity_key", 32'(ps2_key), PAR_EN ? 32'h0 : 32'h61C);
        chk("parity_err", 32'(err_seen), 32'(m_err));

        do_reset();
        frame(8'hE0, 1'b0);
        send_bits(8'h1C, 1'b0, 5);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT + 300);
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        @(negedge clk_sys);
        chk("timeout_err", 32'(err_seen), 32'(m_err));
        frame(8'h29, 1'b0);
        @(negedge clk_sys);
        chk("after_timeout", 32'(ps2_key), 32'h629);

        do_reset();
        frame(8'hE1, 1'b0);
        frame(8'h14, 1'b0);
        frame(8'h77, 1'b0);
        frame(8'hE1, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h14, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h77, 1'b0);
        @(negedge clk_sys);
        chk("pause_no_event", 32'(ps2_key), 32'h0);
        frame(8'h1C, 1'b0);
        @(negedge clk_sys);
        chk("after_pause", 32'(ps2_key), 32'h61C);

        do_reset();
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(4);
        ps2_clk  = 1'b1;
        wait_cyc(HALF);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        frame(8'h1C, 1'b0);
        @(negedge clk_sys);
        chk("glitch_filtered", 32'(ps2_key), 32'h61C);
        chk("glitch_err", 32'(err_seen), 32'(m_err));

        send_bits(8'h5A, 1'b0, 5);
        wait_cyc(HALF);
        RESET_N = 1'b0;
        @(negedge clk_sys);
        chk("midreset_key", 32'(ps2_key), 32'h0);
        chk("midreset_err", 32'(rx_err), 32'h0);
        do_reset();
        frame(8'h29, 1'b0);
        @(negedge clk_sys);
        chk("after_midreset", 32'(ps2_key), 32'h629);
        chk("after_midreset_err", 32'(err_seen), 32'(m_err));

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 11));
            case (r)
                0:       rb = 8'hE0;
                1, 2:    rb = 8'hF0;
                3:       rb = 8'hE1;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            fl = ($urandom_range(0, 7) == 0);
            frame_chk($sformatf("rand%0d", i), rb, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
